desserializador_7bits: RTL and testbench
========================================

# desserializador_7bits

Serial-in, parallel-out 7-bit frame receiver for the display datapath. It takes the serial stream produced by the 7-bit parallel-load transmit shift register and rebuilds the 7-bit column word. The stream carries one start bit, seven data bits sent MSB first (bits[6] first), and one stop bit. The block presents the word with a ready/acknowledge handshake and reports framing errors and overruns.

## Interface
Parameters:
- CICLOS_POR_BIT, default 1: clock cycles per serial bit (N). Legal range 1..255. H = floor(N/2) is the mid-bit sample offset.

Ports:
- clk  input  1  single clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high. It takes effect on the rising edge of clk.
- d  input  1  serial line. Idle high, start bit low. Synchronous to clk.
- lido  input  1  consumer acknowledge; clears pronto.
- bits  output  7  last correctly framed word. bits[6] is the first data bit received.
- pronto  output  1  a word is available and has not been acknowledged.
- ocupado  output  1  a frame is being received.
- erro_quadro  output  1  one-cycle pulse: the stop bit was sampled low.
- sobreposicao  output  1  sticky overrun flag: a word was overwritten before it was acknowledged.

## Operation
- States:
  - OCIOSO (idle)
  - INICIO (start bit)
  - DADOS (data bits)
  - PARADA (stop bit)
- Internal registers:
  - bit-period counter, 8 bits, wide enough for N-1
  - data bit index, 0..6
  - 7-bit shift register
- OCIOSO, d=0 sampled at edge t0: go to INICIO and clear the counter.
  - If H=0 (N=1), the start bit is confirmed at t0 and the state goes directly to DADOS.
- INICIO, at edge t0+H:
  - d=0: confirm the start bit and go to DADOS with index 0.
  - d=1: treat it as a glitch and return to OCIOSO. No flags change.
- DADOS:
  - Data bit k (k=0..6) is sampled at edge t0+H+(k+1)·N.
  - Each sample shifts left into the shift register: sr <= {sr[5:0], d}.
  - After k=6, go to PARADA.
- PARADA, stop bit sampled at edge t0+H+8·N:
  - d=1: load bits from the shift register and set pronto. If pronto was already 1 and lido is 0 on that edge, also set sobreposicao.
  - d=0: pulse erro_quadro. bits, pronto and sobreposicao are unchanged.
  - In both cases return to OCIOSO.
- Line idle requirement: after a framing error, OCIOSO must see d=1 for at least one edge before a new start bit is accepted. This prevents a stuck-low line from retriggering.
- Handshake:
  - lido=1 on an edge with pronto=1 clears pronto on that edge.
  - lido=1 while pronto=0 has no effect.
  - lido on the same edge as a successful stop sample: the new word loads, pronto stays 1, and no overrun is flagged.
  - lido also clears sobreposicao.
- ocupado = 1 in INICIO, DADOS and PARADA; 0 in OCIOSO.
- Shift-register contents are not visible on bits until a frame completes with a valid stop bit.

## Timing
- Reset values:
  - state OCIOSO
  - bits = 7'b0000000
  - pronto = 0, ocupado = 0, erro_quadro = 0, sobreposicao = 0
  - counter and index = 0
- Reset mid-frame discards the partial frame with no flags set. The first edge after reset is released can detect a start bit.
- Latency: bits and pronto become valid on the edge that samples the stop bit, t0+H+8·N. They are visible in the cycle that follows.
  - N=1: 9 edges from start detection to pronto, counting t0 as edge 1.
- Back-to-back frames: a start bit on the edge immediately after the stop sample is accepted, with zero idle cycles required after a valid frame.
- erro_quadro is high for exactly one cycle per bad frame.
- All outputs are registered; there is no combinational path from d or lido to any output.

## Test plan
- N=1, reset then d = 0,1,0,1,1,0,0,1,1 (start, data 1011001, stop) -> bits=7'h59 and pronto=1 after the 9th edge. ocupado=1 for 8 cycles. No errors.
- N=4 (H=2), same frame with each bit held 4 cycles -> bits=7'h59. Samples fall at cycle offsets 2,6,…,34 after t0. A 1-cycle low glitch on an idle line is rejected: ocupado returns to 0 and no flags are set.
- N=1, frame with data 0101010 and stop bit 0 -> erro_quadro pulses for 1 cycle, bits and pronto keep their previous values. A following frame is only accepted after d=1 for one edge.
- Two valid frames 7'h7F then 7'h00 with no lido -> bits=7'h00, pronto=1, sobreposicao=1. Asserting lido for one cycle clears both pronto and sobreposicao.
- lido asserted on the same edge as the stop sample of a second frame -> pronto stays 1, bits takes the new word, sobreposicao=0.
- reset asserted for 1 cycle after the 4th data bit, then a full frame 7'h2A -> outputs return to reset values, then bits=7'h2A and pronto=1. No error or overrun flags.

Source files
------------

// File: rtl/desserializador_7bits.sv
// desserializador_7bits
// Serial-in, parallel-out receiver for 7-bit column words. Each frame is a
// low start bit, seven data bits sent MSB first, and a high stop bit.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous, active-high
//   d            - serial line (idle high, start bit low)
//   lido         - consumer acknowledge: clears pronto and sobreposicao
//   bits         - last correctly framed word (bits[6] = first data bit)
//   pronto       - word available and not yet acknowledged
//   ocupado      - a frame is being received
//   erro_quadro  - one-cycle pulse when the stop bit is sampled low
//   sobreposicao - sticky overrun flag: an unacknowledged word was replaced
//
// Handshake: pronto rises on the edge that samples a good stop bit. The
// consumer holds lido high for at least one edge to take the word. A lido on
// the same edge as a new stop sample counts as taking the old word, so no
// overrun is flagged. All outputs are registered.
module desserializador_7bits #(
    parameter int CICLOS_POR_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic       lido,
    output logic [6:0] bits,
    output logic       pronto,
    output logic       ocupado,
    output logic       erro_quadro,
    output logic       sobreposicao
);

    localparam int         H    = CICLOS_POR_BIT / 2;
    localparam logic [7:0] N_M1 = 8'(CICLOS_POR_BIT - 1);
    // Only meaningful when H > 0; with H = 0 the INICIO state is never entered.
    localparam logic [7:0] H_M1 = (H > 0) ? 8'(H - 1) : 8'd0;

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] INICIO = 2'd1;
    localparam logic [1:0] DADOS  = 2'd2;
    localparam logic [1:0] PARADA = 2'd3;

    logic [1:0] estado;
    logic [7:0] cnt;
    logic [2:0] idx;
    logic [6:0] sr;
    // Set after a framing error; the line must be seen high once before a
    // new start bit is accepted, so a stuck-low line cannot retrigger.
    logic       espera_ocioso;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= OCIOSO;
            cnt           <= 8'd0;
            idx           <= 3'd0;
            sr            <= 7'd0;
            espera_ocioso <= 1'b0;
            bits          <= 7'd0;
            pronto        <= 1'b0;
            ocupado       <= 1'b0;
            erro_quadro   <= 1'b0;
            sobreposicao  <= 1'b0;
        end else begin
            erro_quadro <= 1'b0;

            // Acknowledge; a good stop sample later in this block overrides
            // pronto so the new word stays flagged.
            if (lido) begin
                pronto       <= 1'b0;
                sobreposicao <= 1'b0;
            end

            case (estado)
                OCIOSO: begin
                    cnt <= 8'd0;
                    idx <= 3'd0;
                    if (espera_ocioso) begin
                        if (d) espera_ocioso <= 1'b0;
                    end else if (!d) begin
                        ocupado <= 1'b1;
                        // With one cycle per bit the start bit is already
                        // confirmed on the detecting edge.
                        if (H == 0) estado <= DADOS;
                        else        estado <= INICIO;
                    end
                end

                INICIO: begin
                    if (cnt == H_M1) begin
                        cnt <= 8'd0;
                        if (!d) begin
                            estado <= DADOS;
                            idx    <= 3'd0;
                        end else begin
                            // Glitch: drop back silently.
                            estado  <= OCIOSO;
                            ocupado <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                DADOS: begin
                    if (cnt == N_M1) begin
                        cnt <= 8'd0;
                        sr  <= {sr[5:0], d};
                        if (idx == 3'd6) estado <= PARADA;
                        else             idx    <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                PARADA: begin
                    if (cnt == N_M1) begin
                        cnt     <= 8'd0;
                        estado  <= OCIOSO;
                        ocupado <= 1'b0;
                        if (d) begin
                            bits   <= sr;
                            pronto <= 1'b1;
                            if (pronto && !lido) sobreposicao <= 1'b1;
                        end else begin
                            erro_quadro   <= 1'b1;
                            espera_ocioso <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    estado  <= OCIOSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_desserializador_7bits.sv
// Testbench for desserializador_7bits: a table of per-edge vectors for an
// N=1 instance, plus hand-written sequences for an N=4 instance.
module tb_desserializador_7bits;

    typedef struct {
        logic       rst;
        logic       d;
        logic       lido;
        logic [6:0] bits;
        logic       pronto;
        logic       ocup;
        logic       erro;
        logic       sobre;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N = 1 instance
    logic       rst1 = 1'b1, d1 = 1'b1, lido1 = 1'b0;
    logic [6:0] bits1;
    logic       pronto1, ocup1, erro1, sobre1;

    desserializador_7bits #(.CICLOS_POR_BIT(1)) dut1 (
        .clk(clk), .reset(rst1), .d(d1), .lido(lido1),
        .bits(bits1), .pronto(pronto1), .ocupado(ocup1),
        .erro_quadro(erro1), .sobreposicao(sobre1)
    );

    // N = 4 instance
    logic       rst4 = 1'b1, d4 = 1'b1, lido4 = 1'b0;
    logic [6:0] bits4;
    logic       pronto4, ocup4, erro4, sobre4;

    desserializador_7bits #(.CICLOS_POR_BIT(4)) dut4 (
        .clk(clk), .reset(rst4), .d(d4), .lido(lido4),
        .bits(bits4), .pronto(pronto4), .ocupado(ocup4),
        .erro_quadro(erro4), .sobreposicao(sobre4)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic d, input logic lido,
                                input logic [6:0] b, input logic p, input logic o,
                                input logic e, input logic s);
        vec_t v;
        v.rst = rst; v.d = d; v.lido = lido;
        v.bits = b; v.pronto = p; v.ocup = o; v.erro = e; v.sobre = s;
        tab.push_back(v);
    endfunction

    // Seven data-bit rows, MSB first, all with the same expected outputs.
    function automatic void add_data(input logic [6:0] w, input logic [6:0] b,
                                     input logic p, input logic s);
        for (int i = 6; i >= 0; i--) add(1'b0, w[i], 1'b0, b, p, 1'b1, 1'b0, s);
    endfunction

    function automatic void add_data4(input logic [3:0] w, input logic [6:0] b);
        for (int i = 3; i >= 0; i--) add(1'b0, w[i], 1'b0, b, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic step4(input logic rst, input logic d, input logic lido);
        @(negedge clk);
        rst4 = rst; d4 = d; lido4 = lido;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [8:0] fr;
        //    rst d lido  bits   p  o  e  s
        // Reset, then frame 1011001 (0x59)
        add(1, 1, 0, 7'h00, 0, 0, 0, 0);
        add(0, 1, 0, 7'h00, 0, 0, 0, 0);
        add(0, 0, 0, 7'h00, 0, 1, 0, 0);
        add_data(7'b1011001, 7'h00, 0, 0);
        add(0, 1, 0, 7'h59, 1, 0, 0, 0);
        add(0, 1, 1, 7'h59, 0, 0, 0, 0);
        add(0, 1, 0, 7'h59, 0, 0, 0, 0);
        // Framing error: data 0101010, stop low; then low line ignored
        add(0, 0, 0, 7'h59, 0, 1, 0, 0);
        add_data(7'b0101010, 7'h59, 0, 0);
        add(0, 0, 0, 7'h59, 0, 0, 1, 0);
        add(0, 0, 0, 7'h59, 0, 0, 0, 0);
        add(0, 0, 0, 7'h59, 0, 0, 0, 0);
        add(0, 1, 0, 7'h59, 0, 0, 0, 0);
        // 0x7F then 0x00 back to back, no lido -> overrun
        add(0, 0, 0, 7'h59, 0, 1, 0, 0);
        add_data(7'h7F, 7'h59, 0, 0);
        add(0, 1, 0, 7'h7F, 1, 0, 0, 0);
        add(0, 0, 0, 7'h7F, 1, 1, 0, 0);
        add_data(7'h00, 7'h7F, 1, 0);
        add(0, 1, 0, 7'h00, 1, 0, 0, 1);
        add(0, 1, 1, 7'h00, 0, 0, 0, 0);
        // 0x15, then 0x6A with lido on its stop edge -> no overrun
        add(0, 0, 0, 7'h00, 0, 1, 0, 0);
        add_data(7'h15, 7'h00, 0, 0);
        add(0, 1, 0, 7'h15, 1, 0, 0, 0);
        add(0, 0, 0, 7'h15, 1, 1, 0, 0);
        add_data(7'h6A, 7'h15, 1, 0);
        add(0, 1, 1, 7'h6A, 1, 0, 0, 0);
        add(0, 1, 1, 7'h6A, 0, 0, 0, 0);
        // Reset after 4th data bit, then frame 0x2A
        add(0, 0, 0, 7'h6A, 0, 1, 0, 0);
        add_data4(4'b1010, 7'h6A);
        add(1, 1, 0, 7'h00, 0, 0, 0, 0);
        add(0, 0, 0, 7'h00, 0, 1, 0, 0);
        add_data(7'h2A, 7'h00, 0, 0);
        add(0, 1, 0, 7'h2A, 1, 0, 0, 0);

        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            rst1 = tab[i].rst; d1 = tab[i].d; lido1 = tab[i].lido;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d bits", i), 32'(bits1), 32'(tab[i].bits));
            chk($sformatf("v%0d pronto", i), 32'(pronto1), 32'(tab[i].pronto));
            chk($sformatf("v%0d ocupado", i), 32'(ocup1), 32'(tab[i].ocup));
            chk($sformatf("v%0d erro_quadro", i), 32'(erro1), 32'(tab[i].erro));
            chk($sformatf("v%0d sobreposicao", i), 32'(sobre1), 32'(tab[i].sobre));
        end

        // N=4: reset values
        step4(1'b1, 1'b1, 1'b0);
        chk("n4 reset bits", 32'(bits4), 32'h0);
        chk("n4 reset pronto", 32'(pronto4), 32'h0);
        chk("n4 reset ocupado", 32'(ocup4), 32'h0);
        step4(1'b0, 1'b1, 1'b0);

        // N=4: frame 0x59, each bit held 4 cycles; stop sampled at offset 34
        fr = 9'b0_1011001_1;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 4; j++) begin
                step4(1'b0, fr[8 - i], 1'b0);
                if (i * 4 + j == 0 || i * 4 + j == 33) begin
                    chk($sformatf("n4 e%0d ocupado", i * 4 + j), 32'(ocup4), 32'h1);
                    chk($sformatf("n4 e%0d pronto", i * 4 + j), 32'(pronto4), 32'h0);
                end
                if (i * 4 + j == 34) begin
                    chk("n4 stop bits", 32'(bits4), 32'h59);
                    chk("n4 stop pronto", 32'(pronto4), 32'h1);
                    chk("n4 stop ocupado", 32'(ocup4), 32'h0);
                    chk("n4 stop erro", 32'(erro4), 32'h0);
                end
            end
        end

        // N=4: one-cycle low glitch on an idle line
        step4(1'b0, 1'b0, 1'b0);
        chk("glitch t0 ocupado", 32'(ocup4), 32'h1);
        step4(1'b0, 1'b1, 1'b0);
        chk("glitch t1 ocupado", 32'(ocup4), 32'h1);
        step4(1'b0, 1'b1, 1'b0);
        chk("glitch t2 ocupado", 32'(ocup4), 32'h0);
        chk("glitch t2 erro", 32'(erro4), 32'h0);
        step4(1'b0, 1'b1, 1'b0);
        chk("glitch bits", 32'(bits4), 32'h59);
        chk("glitch pronto", 32'(pronto4), 32'h1);
        chk("glitch sobre", 32'(sobre4), 32'h0);
        chk("glitch erro", 32'(erro4), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
